// File: rtl/min_search_seq_if.sv
// Handshake bundle for the min-search sequencer:
// job start, operand stream and result beat.
interface min_search_seq_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W:0]   len;
    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic             out_valid;
    logic [DW-1:0]    out_min;
    logic [CNT_W-1:0] out_idx;
    logic             out_err;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_min, out_idx,
        input  out_err, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_min, out_idx,
        output out_err, busy
    );
endinterface

// File: rtl/min_search_seq.sv
// Streams LEN operands through one registered min-compare,
// tracking the running minimum and its first index.
module min_search_seq #(
    parameter int DW    = 8,
    parameter int CNT_W = 4
) (
    input logic            clk,
    input logic            rst_n,
    min_search_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W:0] MAX_LEN = {1'b1, {CNT_W{1'b0}}};

    state_t           state;
    state_t           state_nx;
    logic [CNT_W:0]   cnt;
    logic [CNT_W:0]   cnt_nx;
    logic [CNT_W:0]   len_r;
    logic [DW-1:0]    min_r;
    logic [CNT_W-1:0] idx_r;
    logic             err_r;
    logic             len_ok;
    logic             job_go;
    logic             accept;
    logic             last_beat;
    logic             take;

    assign len_ok    = (bus.len != '0) && (bus.len <= MAX_LEN);
    assign job_go    = (state == IDLE) && bus.start;
    assign accept    = (state == RUN) && bus.in_valid;
    assign cnt_nx    = cnt + 1'b1;
    assign last_beat = accept && (cnt_nx == len_r);
    // First beat always loads; later beats only on strictly smaller.
    assign take      = accept && ((cnt == '0) || (bus.in_data < min_r));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start) state_nx = len_ok ? RUN : DONE;
            RUN:  if (last_beat) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Job setup, beat counting and running-minimum datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            len_r <= '0;
            min_r <= '0;
            idx_r <= '0;
            err_r <= 1'b0;
        end else begin
            if (job_go) begin
                cnt <= '0;
                if (len_ok) begin
                    len_r <= bus.len;
                    err_r <= 1'b0;
                end else begin
                    err_r <= 1'b1;
                    min_r <= '1;
                    idx_r <= '0;
                end
            end
            if (accept) begin
                cnt <= cnt_nx;
                if (take) begin
                    min_r <= bus.in_data;
                    idx_r <= cnt[CNT_W-1:0];
                end
            end
        end
    end

    assign bus.in_ready  = (state == RUN);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_min   = min_r;
    assign bus.out_idx   = idx_r;
    assign bus.out_err   = err_r;
endmodule

// File: tb/tb_min_search_seq.sv
// Randomised scoreboard bench for min_search_seq:
// driver pushes expected results, monitor pops on out_valid.
module tb_min_search_seq;
    localparam int DW    = 8;
    localparam int CNT_W = 4;
    localparam int MAXL  = 1 << CNT_W;

    typedef logic [DW-1:0] dq_t[$];
    typedef struct packed {
        logic [DW-1:0]    mn;
        logic [CNT_W-1:0] idx;
        logic             err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    min_search_seq_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

    min_search_seq #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: minimum value, then the first position holding it.
    function automatic exp_t model(input int len, input dq_t d);
        exp_t e;
        int   first;
        if (len < 1 || len > MAXL) begin
            e.mn  = '1;
            e.idx = '0;
            e.err = 1'b1;
            return e;
        end
        e.mn = d[0];
        for (int i = 1; i < len; i++)
            if (d[i] < e.mn) e.mn = d[i];
        first = 0;
        for (int i = len - 1; i >= 0; i--)
            if (d[i] == e.mn) first = i;
        e.idx = first[CNT_W-1:0];
        e.err = 1'b0;
        return e;
    endfunction

    // Monitor: compare every presented result; retire on handshake.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got out_valid=1 expected none");
            end else begin
                check("out_min", bus.out_min, sbq[0].mn);
                check("out_idx", bus.out_idx, sbq[0].idx);
                check("out_err", bus.out_err, sbq[0].err);
                if (bus.out_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // gap < 0 picks a random 0..2 stall before each beat.
    task automatic run_job(input int len, input dq_t d, input int gap,
                           input int rdly, input bit poke);
        exp_t e;
        int   g;
        e = model(len, d);
        sbq.push_back(e);
        bus.start = 1'b1;
        bus.len   = len[CNT_W:0];
        step();
        bus.start = 1'b0;
        bus.len   = CNT_W'($urandom);
        if (e.err) begin
            check("err_latency", bus.out_valid, 1);
        end else begin
            check("busy_run", bus.busy, 1);
            for (int i = 0; i < len; i++) begin
                g = (gap < 0) ? $urandom_range(0, 2) : gap;
                repeat (g) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = DW'($urandom);
                    step();
                    check("in_ready_stall", bus.in_ready, 1);
                end
                bus.in_valid = 1'b1;
                bus.in_data  = d[i];
                if (poke && i == 1) begin
                    bus.start = 1'b1;
                    bus.len   = 1;
                end
                step();
                bus.start = 1'b0;
            end
            bus.in_valid = 1'b0;
            bus.in_data  = DW'($urandom);
            check("out_latency", bus.out_valid, 1);
        end
        repeat (rdly) begin
            step();
            check("hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        if (poke) begin
            bus.start = 1'b1;
            bus.len   = 1;
        end
        step();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("idle_valid", bus.out_valid, 0);
        check("idle_busy", bus.busy, 0);
    endtask

    initial begin
        dq_t d;
        int  len;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_min", bus.out_min, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_err", bus.out_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        d = {8'd40, 8'd17, 8'd99, 8'd17, 8'd200};
        run_job(5, d, 0, 0, 1'b0);
        d = {8'd9, 8'd8, 8'd7};
        run_job(3, d, 2, 4, 1'b0);
        d = {};
        for (int i = 0; i < 16; i++) d.push_back(DW'(255 - 17 * i));
        run_job(16, d, 0, 1, 1'b0);
        run_job(17, d, 0, 0, 1'b0);
        d = {};
        run_job(0, d, 0, 2, 1'b0);
        d = {8'd60, 8'd61, 8'd3, 8'd90};
        run_job(4, d, 0, 1, 1'b1);

        bus.start = 1'b1;
        bus.len   = 4;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(50 + i);
            step();
        end
        bus.in_data = 8'd5;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_out_min", bus.out_min, 0);
        check("abort_out_idx", bus.out_idx, 0);
        check("abort_out_err", bus.out_err, 0);
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_busy", bus.busy, 0);
        d = {8'd33};
        run_job(1, d, 0, 0, 1'b0);

        for (int j = 0; j < 30; j++) begin
            if ($urandom_range(0, 5) == 0)
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 31);
            else
                len = $urandom_range(1, MAXL);
            d = {};
            for (int i = 0; i < len; i++)
                d.push_back(($urandom_range(0, 1) == 0) ?
                            DW'($urandom_range(0, 7)) : DW'($urandom));
            run_job(len, d, -1, $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
        end

        repeat (3) step();
        check("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
